// File: rtl/rj45_led_scheduler_if.sv
// Requester-side bus for the RJ45 LED scheduler: level requests with
// per-requester LED values and bit-enables, one-hot single-cycle grants.
interface rj45_led_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0][7:0] req_vals;
    logic [NUM_REQ-1:0][7:0] req_mask;
    logic [NUM_REQ-1:0]      grant;

    modport master (output req, req_vals, req_mask, input grant);
    modport slave  (input req, req_vals, req_mask, output grant);
endinterface

// File: rtl/rj45_led_scheduler.sv
// RJ45 LED scheduler: merges masked requester updates into a shadow register
// and paces frames to the slow serial LED driver (hold strobe, then gap).
// Optional blink support is compiled in with `define RJ45_LED_BLINK_EN.
module rj45_led_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int HOLD_CYCLES    = 128,
    parameter int GAP_CYCLES     = 1152,
    parameter int REFRESH_CYCLES = 1048576
`ifdef RJ45_LED_BLINK_EN
    ,
    parameter int BLINK_HALF     = 4194304
`endif
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    rj45_led_scheduler_if.slave  req_if,
`ifdef RJ45_LED_BLINK_EN
    input  logic [7:0]           blink_mask,
`endif
    output logic [7:0]           led_vals,
    output logic                 write_request,
    output logic                 busy
);
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int REF_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [REF_W-1:0]   refresh_cnt;
    logic [7:0]         shadow;
    logic [7:0]         frame;
    logic               dirty;
    logic               blink_set;
    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [PTR_W-1:0]   win;

    function automatic logic [PTR_W-1:0] wrap_idx(input int v);
        return (v >= NUM_REQ) ? PTR_W'(v - NUM_REQ) : PTR_W'(v);
    endfunction

    // A requester sitting in its grant cycle is skipped so one update is never applied twice.
    assign elig = req_if.req & ~req_if.grant;

    // Round-robin search starting at the pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && elig[wrap_idx(int'(rr_ptr) + k)]) begin
                found = 1'b1;
                win   = wrap_idx(int'(rr_ptr) + k);
            end
        end
    end

    // Apply the winner's masked update to the shadow and acknowledge it next cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            req_if.grant <= '0;
            rr_ptr       <= '0;
            shadow       <= '0;
        end else begin
            req_if.grant <= found ? (NUM_REQ'(1) << win) : '0;
            if (found) begin
                rr_ptr <= (win == PTR_LAST) ? '0 : win + 1'b1;
                shadow <= (shadow & ~req_if.req_mask[win]) |
                          (req_if.req_vals[win] & req_if.req_mask[win]);
            end
        end
    end

`ifdef RJ45_LED_BLINK_EN
    localparam int PH_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(BLINK_HALF - 1);

    logic [PH_W-1:0] phase_cnt;
    logic            phase;

    // Free-running blink phase; phase low blanks the blinking bits.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase_cnt <= '0;
            phase     <= 1'b0;
        end else if (phase_cnt == PH_LAST) begin
            phase_cnt <= '0;
            phase     <= ~phase;
        end else begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    // A toggle only needs a frame when some lit bit actually blinks.
    assign blink_set = (phase_cnt == PH_LAST) && |(blink_mask & shadow);
    assign frame     = shadow & ~(blink_mask & {8{~phase}});
`else
    assign blink_set = 1'b0;
    assign frame     = shadow;
`endif

    // Frame pacing: IDLE launches a frame, SEND holds the strobe, WAIT covers one driver frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= WAIT;
            cnt           <= '0;
            refresh_cnt   <= '0;
            led_vals      <= '0;
            write_request <= 1'b0;
            busy          <= 1'b1;
            dirty         <= 1'b1;
        end else begin
            if (refresh_cnt != REF_LAST) refresh_cnt <= refresh_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (dirty || refresh_cnt == REF_LAST) begin
                        state         <= SEND;
                        led_vals      <= frame;
                        dirty         <= 1'b0;
                        refresh_cnt   <= '0;
                        write_request <= 1'b1;
                        busy          <= 1'b1;
                        cnt           <= '0;
                    end
                end
                SEND: begin
                    if (cnt == HOLD_LAST) begin
                        write_request <= 1'b0;
                        cnt           <= '0;
                        state         <= WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= WAIT;
            endcase
            // An update landing on the launch edge misses this frame and keeps dirty for the next.
            if (found || blink_set) dirty <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rj45_led_scheduler.sv
// Directed bench for rj45_led_scheduler: reset, masked merge, arbitration,
// frame pacing, refresh resend and mid-frame reset.
module tb_rj45_led_scheduler;
    localparam int NR      = 4;
    localparam int HOLD    = 128;
    localparam int GAP     = 1152;
    localparam int REFRESH = 4000;
    localparam int PERIOD  = HOLD + GAP + 1;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] led_vals;
    logic       write_request;
    logic       busy;
`ifdef RJ45_LED_BLINK_EN
    logic [7:0] blink_mask = 8'h00;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_starts = 0;
    int start_cyc = 0;
    logic [7:0] start_val = 8'h00;

    rj45_led_scheduler_if #(.NUM_REQ(NR)) rif ();

    rj45_led_scheduler #(
        .NUM_REQ(NR), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .REFRESH_CYCLES(REFRESH)
`ifdef RJ45_LED_BLINK_EN
        , .BLINK_HALF(4096)
`endif
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .req_if(rif),
`ifdef RJ45_LED_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .led_vals(led_vals),
        .write_request(write_request),
        .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Record each frame start (cycle number of the launching edge and its value).
    always @(posedge write_request) begin
        #1;
        n_starts  = n_starts + 1;
        start_cyc = cyc;
        start_val = led_vals;
    end

    task automatic do_req(input int i, input logic [7:0] v, input logic [7:0] m, input string nm);
        int lat;
        logic [3:0] exp_g;
        lat = 0;
        exp_g = 4'b0001 << i;
        @(negedge sys_clk);
        rif.req[i] = 1'b1; rif.req_vals[i] = v; rif.req_mask[i] = m;
        do begin @(negedge sys_clk); lat++; end while (rif.grant[i] !== 1'b1 && lat < 10);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL %s latency: got %0d want 1", nm, lat); end
        checks++;
        if (rif.grant !== exp_g) begin errors++; $display("FAIL %s grant: got %b want %b", nm, rif.grant, exp_g); end
        rif.req[i] = 1'b0;
    endtask

    task automatic wait_frame(input int limit, input string nm);
        int n0 = n_starts;
        int t = 0;
        while (n_starts == n0 && t < limit) begin @(negedge sys_clk); t++; end
        checks++;
        if (n_starts == n0) begin errors++; $display("FAIL %s timeout: no frame within %0d cycles", nm, limit); end
    endtask

    task automatic check_frame(input int prev, input int gap, input logic [7:0] val, input string nm);
        checks++;
        if (start_cyc - prev != gap) begin
            errors++; $display("FAIL %s spacing: got %0d want %0d", nm, start_cyc - prev, gap);
        end
        checks++;
        if (start_val !== val) begin errors++; $display("FAIL %s led_vals: got %h want %h", nm, start_val, val); end
    endtask

    task automatic check_reset_outs(input string nm);
        checks++;
        if (rif.grant !== 4'b0000 || led_vals !== 8'h00 || write_request !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s: grant=%b led=%h wr=%b busy=%b want 0000/00/0/1", nm, rif.grant, led_vals, write_request, busy);
        end
    endtask

    task automatic test_reset;
        int rel;
        int h;
        sys_rst_n = 1'b0;
        rif.req = '0; rif.req_vals = '0; rif.req_mask = '0;
        repeat (3) @(negedge sys_clk);
        check_reset_outs("reset_state");
        sys_rst_n = 1'b1;
        rel = cyc;
        wait_frame(GAP + 10, "first_frame");
        check_frame(rel, GAP + 1, 8'h00, "first_frame");
        h = 0;
        while (write_request === 1'b1 && h < HOLD + 10) begin h++; @(negedge sys_clk); end
        checks++;
        if (h != HOLD) begin errors++; $display("FAIL hold_len: got %0d want %0d", h, HOLD); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_wait: got %b want 1", busy); end
    endtask

    task automatic test_masked_update;
        int prev;
        prev = start_cyc;
        do_req(0, 8'hFF, 8'h0F, "req0");
        checks++;
        if (led_vals !== 8'h00) begin errors++; $display("FAIL led_hold0: got %h want 00", led_vals); end
        wait_frame(PERIOD + 10, "frame_0f");
        check_frame(prev, PERIOD, 8'h0F, "frame_0f");
        prev = start_cyc;
        repeat (5) @(negedge sys_clk);
        do_req(2, 8'h00, 8'h03, "req2");
        wait_frame(PERIOD + 10, "frame_0c");
        check_frame(prev, PERIOD, 8'h0C, "frame_0c");
    endtask

    task automatic test_update_during_wait;
        int prev;
        int n0;
        int t;
        logic changed;
        prev = start_cyc;
        repeat (300) @(negedge sys_clk);
        do_req(1, 8'hA0, 8'hF0, "req1");
        changed = 1'b0;
        n0 = n_starts;
        t = 0;
        while (n_starts == n0 && t < PERIOD + 10) begin
            @(negedge sys_clk); t++;
            if (n_starts == n0 && led_vals !== 8'h0C) changed = 1'b1;
        end
        checks++;
        if (changed) begin errors++; $display("FAIL led_mid_frame: got change want stable 0c"); end
        check_frame(prev, PERIOD, 8'hAC, "frame_ac");
        n0 = n_starts;
        repeat (1400) @(negedge sys_clk);
        checks++;
        if (n_starts != n0) begin errors++; $display("FAIL extra_frames: got %0d want 0", n_starts - n0); end
    endtask

    task automatic test_refresh;
        int prev;
        prev = start_cyc;
        wait_frame(REFRESH, "refresh");
        check_frame(prev, REFRESH, 8'hAC, "refresh");
    endtask

    task automatic test_zero_mask_resend;
        int prev;
        prev = start_cyc;
        repeat (200) @(negedge sys_clk);
        do_req(3, 8'h55, 8'h00, "req3_zero");
        wait_frame(PERIOD + 10, "zero_mask");
        check_frame(prev, PERIOD, 8'hAC, "zero_mask");
    endtask

    task automatic test_reset_mid_send;
        repeat (10) @(negedge sys_clk);
        checks++;
        if (write_request !== 1'b1) begin errors++; $display("FAIL in_send: got wr=%b want 1", write_request); end
        #1 sys_rst_n = 1'b0;
        #1;
        check_reset_outs("reset_mid_send");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        @(negedge sys_clk);
        rif.req_mask = '0;
        rif.req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            exp_g = 4'b0001 << k;
            checks++;
            if (rif.grant !== exp_g) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", k, rif.grant, exp_g); end
            rif.req[k] = 1'b0;
        end
        @(negedge sys_clk);
        checks++;
        if (rif.grant !== 4'b0000) begin errors++; $display("FAIL rr_idle: got %b want 0000", rif.grant); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_g;
        rif.req = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            @(negedge sys_clk);
            exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            checks++;
            if (rif.grant !== exp_g) begin errors++; $display("FAIL alt_grant[%0d]: got %b want %b", k, rif.grant, exp_g); end
        end
        rif.req = '0;
    endtask

`ifdef RJ45_LED_BLINK_EN
    task automatic test_blink;
        logic seen0;
        logic seen1;
        seen0 = 1'b0; seen1 = 1'b0;
        blink_mask = 8'h01;
        do_req(0, 8'h01, 8'hFF, "req0_blink");
        for (int k = 0; k < 4; k++) begin
            wait_frame(5000, "blink");
            if (start_val === 8'h00) seen0 = 1'b1;
            if (start_val === 8'h01) seen1 = 1'b1;
        end
        checks++;
        if (!(seen0 && seen1)) begin errors++; $display("FAIL blink: seen00=%b seen01=%b want both", seen0, seen1); end
    endtask
`endif

    initial begin
        test_reset();
        test_masked_update();
        test_update_during_wait();
        test_refresh();
        test_zero_mask_resend();
        test_reset_mid_send();
        test_round_robin();
        test_back_to_back();
`ifdef RJ45_LED_BLINK_EN
        test_blink();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
